alu_sequencer: RTL and testbench

- Multi-cycle execution controller; drives the 12-bit combinational ALU (SrcA, SrcB, 3-bit control) and consumes its result and zero flag.
- Accepts 12-bit instructions over a valid/ready handshake and decodes them into ALU operations.
- Owns an 8x12 register file and writes ALU results back to it; reports compare outcomes as branch_taken.
- Sits between instruction fetch and the ALU in the 12-bit CPU datapath.

---
 rtl/alu_sequencer.sv | 173 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller in front of an external combinational ALU.
// Accepts one 12-bit instruction at a time over valid/ready and decodes it.
// Drives the ALU operands and control code, captures the ALU result, and writes
// it back to an internal 8-entry register file. A BEQ reports its outcome on branch_taken.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   instr_valid/ready     instruction handshake; instr = {op, rd, rs1, rs2} or {op, rd, imm6}
//   alu_srca/srcb/ctrl    registered ALU operands and control code
//   alu_result/alu_zero   combinational ALU response
//   wb_valid/addr/data    one-cycle register write report
//   branch_taken          one-cycle pulse when a BEQ compares equal
//   dbg_addr/dbg_data     combinational register file read port
module alu_sequencer #(
  parameter int unsigned DW   = 12,
  parameter int unsigned NREG = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [11:0]               instr,
  output logic [DW-1:0]             alu_srca,
  output logic [DW-1:0]             alu_srcb,
  output logic [2:0]                alu_ctrl,
  input  logic [DW-1:0]             alu_result,
  input  logic                      alu_zero,
  output logic                      wb_valid,
  output logic [$clog2(NREG)-1:0]   wb_addr,
  output logic [DW-1:0]             wb_data,
  output logic                      branch_taken,
  input  logic [$clog2(NREG)-1:0]   dbg_addr,
  output logic [DW-1:0]             dbg_data
);

  localparam int unsigned AW = $clog2(NREG);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_WB     = 2'd3;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_BEQ = 3'b110;
  localparam logic [2:0] OP_LDI = 3'b111;
  localparam logic [2:0] CTRL_ADD = 3'b001;

  logic [1:0]    state_q, state_d;
  logic [11:0]   instr_q, instr_d;
  logic          ready_q, ready_d;
  logic [DW-1:0] srca_q, srca_d;
  logic [DW-1:0] srcb_q, srcb_d;
  logic [2:0]    ctrl_q, ctrl_d;
  logic          wb_valid_q, wb_valid_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          branch_q, branch_d;

  logic [DW-1:0] rf_q [NREG];

  logic [2:0]    op;
  logic [AW-1:0] rd, rs1, rs2;
  logic [DW-1:0] rs1_data, rs2_data, imm;

  // Field decode of the captured instruction
  assign op  = instr_q[11:9];
  assign rd  = AW'(instr_q[8:6]);
  assign rs1 = AW'(instr_q[5:3]);
  assign rs2 = AW'(instr_q[2:0]);
  assign imm = DW'(instr_q[5:0]);

  // r0 is hard-wired to zero on every read port
  assign rs1_data = (rs1 == '0) ? '0 : rf_q[rs1];
  assign rs2_data = (rs2 == '0) ? '0 : rf_q[rs2];
  assign dbg_data = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      ready_q    <= 1'b1;
      srca_q     <= '0;
      srcb_q     <= '0;
      ctrl_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      branch_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      ready_q    <= ready_d;
      srca_q     <= srca_d;
      srcb_q     <= srcb_d;
      ctrl_q     <= ctrl_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      branch_q   <= branch_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    srca_d     = srca_q;
    srcb_d     = srcb_q;
    ctrl_d     = ctrl_q;
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    branch_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (instr_valid && ready_q) begin
          instr_d = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // NOP leaves the ALU operands untouched and returns straight to IDLE
        if (op == OP_NOP) begin
          state_d = S_IDLE;
        end else begin
          srca_d  = (op == OP_LDI) ? '0 : rs1_data;
          srcb_d  = (op == OP_LDI) ? imm : rs2_data;
          ctrl_d  = (op == OP_LDI) ? CTRL_ADD : op;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // The ALU response is captured straight into the WB-cycle outputs
        if (op == OP_BEQ) begin
          branch_d = alu_zero;
        end else begin
          wb_valid_d = 1'b1;
          wb_addr_d  = rd;
          wb_data_d  = alu_result;
        end
        state_d = S_WB;
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // Register file; the write lands on the edge that ends the WB cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        rf_q[i] <= '0;
      end
    end else if ((state_q == S_WB) && wb_valid_q && (wb_addr_q != '0)) begin
      rf_q[wb_addr_q] <= wb_data_q;
    end
  end

  assign instr_ready  = ready_q;
  assign alu_srca     = srca_q;
  assign alu_srcb     = srcb_q;
  assign alu_ctrl     = ctrl_q;
  assign wb_valid     = wb_valid_q;
  assign wb_addr      = wb_addr_q;
  assign wb_data      = wb_data_q;
  assign branch_taken = branch_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: behavioural ALU, instruction-level reference model,
// scoreboard queues for writeback/branch pulses and EXEC-cycle ALU drive.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [11:0] instr = '0;
  logic [11:0] alu_srca, alu_srcb, alu_result;
  logic [2:0]  alu_ctrl;
  logic        alu_zero;
  logic        wb_valid, branch_taken;
  logic [2:0]  wb_addr;
  logic [11:0] wb_data;
  logic [2:0]  dbg_addr = '0;
  logic [11:0] dbg_data;

  alu_sequencer #(.DW(12), .NREG(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .branch_taken(branch_taken),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural 12-bit ALU
  always_comb begin
    case (alu_ctrl)
      3'b001:  alu_result = alu_srca + alu_srcb;
      3'b010:  alu_result = alu_srca - alu_srcb;
      3'b011:  alu_result = alu_srca & alu_srcb;
      3'b100:  alu_result = alu_srca | alu_srcb;
      3'b101:  alu_result = alu_srca ^ alu_srcb;
      3'b110:  alu_result = alu_srca - alu_srcb;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 12'h000);
  end

  typedef struct { int cyc; bit br; logic [2:0] addr; logic [11:0] data; } ev_t;
  typedef struct { int cyc; logic [2:0] ctrl; logic [11:0] a; logic [11:0] b; } op_t;

  ev_t evq[$];
  op_t opq[$];
  logic [11:0] mreg [8];
  int cyc = 0;
  int busy = 0;
  int n_cmp = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle out of reset, compare pulses and ALU drive against the queues
  always @(negedge clk) begin
    ev_t e;
    op_t o;
    logic [1:0] exp_p;
    if (rst_n) begin
      exp_p = 2'b00;
      if (evq.size() > 0 && evq[0].cyc == cyc) exp_p = evq[0].br ? 2'b01 : 2'b10;
      check("wb_valid/branch_taken", {30'd0, wb_valid, branch_taken}, {30'd0, exp_p});
      if (exp_p != 2'b00) begin
        e = evq.pop_front();
        if (!e.br) begin
          check("wb_addr", {29'd0, wb_addr}, {29'd0, e.addr});
          check("wb_data", {20'd0, wb_data}, {20'd0, e.data});
        end
      end
      if (opq.size() > 0 && opq[0].cyc == cyc) begin
        o = opq.pop_front();
        check("alu_ctrl", {29'd0, alu_ctrl}, {29'd0, o.ctrl});
        check("alu_srca", {20'd0, alu_srca}, {20'd0, o.a});
        check("alu_srcb", {20'd0, alu_srcb}, {20'd0, o.b});
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Instruction-level reference: execute at accept time, schedule observable effects
  task automatic model(input logic [11:0] ins);
    logic [2:0] op, rd, r1, r2;
    logic [11:0] a, b, res;
    op_t o;
    ev_t e;
    op = ins[11:9]; rd = ins[8:6]; r1 = ins[5:3]; r2 = ins[2:0];
    a = mreg[r1];
    b = mreg[r2];
    if (op == 3'd7) begin
      a = 12'h000;
      b = {6'b0, ins[5:0]};
    end
    if (op == 3'd0) begin
      busy = 1;
      return;
    end
    case (op)
      3'd1:    res = a + b;
      3'd2:    res = a - b;
      3'd3:    res = a & b;
      3'd4:    res = a | b;
      3'd5:    res = a ^ b;
      3'd6:    res = a - b;
      default: res = b;
    endcase
    o.cyc = cyc + 2; o.ctrl = (op == 3'd7) ? 3'd1 : op; o.a = a; o.b = b;
    opq.push_back(o);
    e.cyc = cyc + 3; e.addr = rd; e.data = res;
    if (op == 3'd6) begin
      e.br = 1'b1;
      if (a == b) evq.push_back(e);
    end else begin
      e.br = 1'b0;
      evq.push_back(e);
      if (rd != 3'd0) mreg[rd] = res;
    end
    busy = 3;
  endtask

  task automatic wait_free(input bit hold);
    while (busy > 0) begin
      check("instr_ready low", {31'd0, instr_ready}, 32'd0);
      instr_valid = hold;
      instr = 12'($urandom);
      tick();
      busy--;
    end
  endtask

  task automatic send(input logic [11:0] ins, input bit hold);
    wait_free(hold);
    check("instr_ready high", {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1;
    instr = ins;
    model(ins);
    tick();
    instr_valid = hold;
    instr = 12'($urandom);
  endtask

  task automatic idle(input int n);
    wait_free(1'b0);
    instr_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic dump();
    idle(0);
    for (int r = 0; r < 8; r++) begin
      dbg_addr = 3'(r);
      tick();
      check($sformatf("dbg r%0d", r), {20'd0, dbg_data}, {20'd0, mreg[r]});
    end
  endtask

  function automatic logic [11:0] enc(input int op, input int rd, input int r1, input int r2);
    return {3'(op), 3'(rd), 3'(r1), 3'(r2)};
  endfunction

  function automatic logic [11:0] ldi(input int rd, input int imm);
    return {3'b111, 3'(rd), 6'(imm)};
  endfunction

  initial begin
    logic [11:0] ins;
    for (int r = 0; r < 8; r++) mreg[r] = '0;
    tick();
    tick();
    check("reset alu_srca", {20'd0, alu_srca}, 32'd0);
    check("reset alu_srcb", {20'd0, alu_srcb}, 32'd0);
    check("reset alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
    check("reset wb_addr", {29'd0, wb_addr}, 32'd0);
    check("reset wb_data", {20'd0, wb_data}, 32'd0);
    check("reset wb_valid", {31'd0, wb_valid}, 32'd0);
    check("reset branch_taken", {31'd0, branch_taken}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("ready after reset", {31'd0, instr_ready}, 32'd1);

    // Directed sequence
    send(ldi(1, 5), 1'b0);
    send(ldi(2, 3), 1'b0);
    dump();
    send(enc(1, 3, 1, 2), 1'b0);
    send(enc(2, 4, 2, 1), 1'b0);
    send(enc(5, 5, 1, 2), 1'b0);
    send(enc(6, 0, 1, 1), 1'b0);
    send(enc(6, 0, 1, 2), 1'b0);
    send(ldi(0, 7), 1'b0);
    send(enc(1, 6, 0, 1), 1'b0);
    dump();
    check("r3 add", {20'd0, mreg[3]}, 32'h008);
    check("r4 sub wrap", {20'd0, mreg[4]}, 32'hFFE);

    // instr_valid held high, instructions changing while not ready
    send(enc(3, 7, 3, 4), 1'b1);
    send(enc(4, 6, 5, 4), 1'b1);
    send(enc(0, 0, 0, 0), 1'b1);
    send(enc(2, 5, 0, 1), 1'b1);
    dump();

    // Reset during EXEC of ADD r7 aborts it
    send(enc(1, 7, 1, 2), 1'b0);
    check("ready low in DECODE", {31'd0, instr_ready}, 32'd0);
    instr_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    evq.delete();
    opq.delete();
    for (int r = 0; r < 8; r++) mreg[r] = '0;
    busy = 0;
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("ready after mid reset", {31'd0, instr_ready}, 32'd1);
    dump();

    // Randomized instruction stream
    for (int i = 0; i < 150; i++) begin
      ins = 12'($urandom);
      send(ins, 1'($urandom_range(0, 1)));
      if ((i % 25) == 24) begin
        idle($urandom_range(0, 3));
        dump();
      end
    end
    dump();
    idle(4);
    check("expected pulses drained", evq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
